// File: rtl/ttc_trig_pkg.sv
// rtl/ttc_trig_pkg.sv - shared constants for the TTC trigger receiver
// State indices, FIFO word field widths and the default asynchronous trigger type.
package ttc_trig_pkg;

   localparam int ST_IDLE     = 0;
   localparam int ST_SEND     = 1;
   localparam int ST_WAIT_RDY = 2;
   localparam int ST_STORE    = 3;
   localparam int ST_ERROR    = 4;

   typedef enum logic [4:0] {
      IDLE     = 5'(1 << ST_IDLE),
      SEND     = 5'(1 << ST_SEND),
      WAIT_RDY = 5'(1 << ST_WAIT_RDY),
      STORE    = 5'(1 << ST_STORE),
      ERROR    = 5'(1 << ST_ERROR)
   } state_t;

   localparam logic [4:0] ASYNC_TYPE_DEF = 5'b00100;

   localparam int FIFO_W  = 128;
   localparam int TYPE_W  = 5;
   localparam int ALARM_W = 4;
   localparam int FLAG_W  = 1;

   // FIFO word, LSB first: timestamp, acq_trig_num, event_cnt, type, empty_event, alarms, empty_payload
   function automatic int fifo_off_event(input int trig_num_w, input int ts_w);
      return ts_w + trig_num_w;
   endfunction

   function automatic int fifo_used_w(input int trig_num_w, input int ts_w);
      return fifo_off_event(trig_num_w, ts_w) + trig_num_w + TYPE_W + ALARM_W + 2 * FLAG_W;
   endfunction

endpackage

// File: rtl/acq_ready_timeout.sv
// rtl/acq_ready_timeout.sv - acq_ready wait timer, present only with ACQ_READY_TIMEOUT_EN
// Expires once acq_ready has been low for TIMEOUT_CYC cycles counting the start cycle.
`ifdef ACQ_READY_TIMEOUT_EN
module acq_ready_timeout #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_start,
   input  logic i_ready,
   output logic o_expired
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_armed;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else if (i_start) begin
         r_cnt   <= CNT_W'(1);
         r_armed <= 1'b1;
      end else if (r_armed) begin
         if (i_ready || o_expired) begin
            r_armed <= 1'b0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_expired = r_armed && !i_ready && (r_cnt == LAST);

endmodule
`endif

// File: rtl/ttc_trigger_receiver_multi.sv
// rtl/ttc_trigger_receiver_multi.sv - TTC trigger receiver feeding acquisition and event FIFO
// ACQ_READY_TIMEOUT_EN adds WAIT_RDY with a bounded acq_ready wait; otherwise SEND goes straight to ERROR.
module ttc_trigger_receiver_multi
   import ttc_trig_pkg::*;
#(
   parameter int         NUM_CHAN    = 5,
   parameter int         TRIG_NUM_W  = 24,
   parameter int         TS_W        = 44,
   parameter logic [4:0] ASYNC_TYPE  = ASYNC_TYPE_DEF,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  reset_trig_num,
   input  logic                  reset_trig_timestamp,
   input  logic                  ttc_trigger,
   input  logic [4:0]            trig_type,
   input  logic [NUM_CHAN-1:0]   chan_en,
   input  logic [NUM_CHAN-1:0]   selftrig_seen,
   input  logic                  acq_ready,
   input  logic                  acq_activated,
   input  logic                  clear_error,
   input  logic [3:0]            xadc_alarms,
   output logic                  acq_trigger,
   output logic [4:0]            acq_trig_type,
   output logic [TRIG_NUM_W-1:0] acq_trig_num,
   input  logic                  fifo_ready,
   output logic                  fifo_valid,
   output logic [127:0]          fifo_data,
   output logic [4:0]            state,
   output logic [TRIG_NUM_W-1:0] trig_num,
   output logic [TS_W-1:0]       trig_timestamp,
   output logic [15:0]           dropped_trig_cnt,
   output logic                  error_trig_rate
);

   localparam int                    PAD_W   = FIFO_W - fifo_used_w(TRIG_NUM_W, TS_W);
   localparam logic [TRIG_NUM_W-1:0] NUM_ONE = TRIG_NUM_W'(1);

   state_t                r_state, w_next;
   logic [TRIG_NUM_W-1:0] r_trig_num, r_acq_trig_num, r_event_cnt;
   logic [TS_W-1:0]       r_ts_cnt, r_trig_ts;
   logic [4:0]            r_acq_trig_type;
   logic [3:0]            r_alarms;
   logic                  r_empty_event, r_empty_payload, r_acq_trigger;
   logic [127:0]          r_fifo_data;
   logic [15:0]           r_dropped;
   logic                  w_in_idle, w_trig_idle, w_go_store, w_store_done, w_expired;

`ifdef ACQ_READY_TIMEOUT_EN
   acq_ready_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_start   (r_state[ST_SEND] && !acq_ready),
      .i_ready   (acq_ready),
      .o_expired (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   assign w_in_idle    = r_state[ST_IDLE];
   assign w_trig_idle  = w_in_idle && ttc_trigger;
   assign w_go_store   = acq_ready && (r_state[ST_SEND] || r_state[ST_WAIT_RDY]);
   assign w_store_done = r_state[ST_STORE] && fifo_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:     if (ttc_trigger) w_next = SEND;
`ifdef ACQ_READY_TIMEOUT_EN
         SEND:     w_next = acq_ready ? STORE : WAIT_RDY;
         WAIT_RDY: if (acq_ready) w_next = STORE;
                   else if (w_expired) w_next = ERROR;
`else
         SEND:     w_next = acq_ready ? STORE : ERROR;
`endif
         STORE:    if (fifo_ready) w_next = IDLE;
         ERROR:    if (clear_error) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_trig_num      <= NUM_ONE;
         r_acq_trig_num  <= NUM_ONE;
         r_event_cnt     <= NUM_ONE;
         r_ts_cnt        <= '0;
         r_trig_ts       <= '0;
         r_acq_trig_type <= '0;
         r_alarms        <= '0;
         r_empty_event   <= 1'b0;
         r_empty_payload <= 1'b0;
         r_acq_trigger   <= 1'b0;
         r_fifo_data     <= '0;
         r_dropped       <= '0;
      end else begin
         r_ts_cnt <= reset_trig_timestamp ? '0 : r_ts_cnt + TS_W'(1);
         if (reset_trig_timestamp) r_trig_ts <= '0;
         else if (w_trig_idle)     r_trig_ts <= r_ts_cnt;

         // A counter reset coinciding with a trigger hands out number 1 and moves on to 2.
         if (reset_trig_num) begin
            r_acq_trig_num <= NUM_ONE;
            r_trig_num     <= w_trig_idle ? NUM_ONE + NUM_ONE : NUM_ONE;
         end else if (w_trig_idle) begin
            r_acq_trig_num <= r_trig_num;
            r_trig_num     <= r_trig_num + NUM_ONE;
         end

         if (w_trig_idle) begin
            r_acq_trig_type <= trig_type;
            r_alarms        <= xadc_alarms;
            r_empty_event   <= (trig_type != ASYNC_TYPE) || !acq_activated;
            r_empty_payload <= (trig_type == ASYNC_TYPE) && acq_activated
                               && ((selftrig_seen & chan_en) == '0);
         end else if (w_store_done) begin
            r_empty_event   <= 1'b0;
            r_empty_payload <= 1'b0;
         end

         if (reset_trig_num)                     r_event_cnt <= NUM_ONE;
         else if (w_go_store && !r_empty_event)  r_event_cnt <= r_event_cnt + NUM_ONE;

         r_acq_trigger <= w_go_store && !r_empty_event;
         if (w_go_store) begin
            r_fifo_data <= {{PAD_W{1'b0}}, r_empty_payload, r_alarms, r_empty_event,
                            r_acq_trig_type, r_event_cnt, r_acq_trig_num, r_trig_ts};
         end

         if (ttc_trigger && !w_in_idle && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
      end
   end

   assign state            = r_state;
   assign acq_trigger      = r_acq_trigger;
   assign acq_trig_type    = r_acq_trig_type;
   assign acq_trig_num     = r_acq_trig_num;
   assign fifo_valid       = r_state[ST_STORE];
   assign fifo_data        = r_fifo_data;
   assign trig_num         = r_trig_num;
   assign trig_timestamp   = r_trig_ts;
   assign dropped_trig_cnt = r_dropped;
   assign error_trig_rate  = r_state[ST_ERROR];

endmodule

// File: tb/tb_ttc_trigger_receiver_multi.sv
// tb/tb_ttc_trigger_receiver_multi.sv - directed self-checking bench for ttc_trigger_receiver_multi
module tb_ttc_trigger_receiver_multi;

   logic         clk = 1'b0;
   logic         reset_n, reset_trig_num, reset_trig_timestamp, ttc_trigger;
   logic [4:0]   trig_type;
   logic [4:0]   chan_en, selftrig_seen;
   logic         acq_ready, acq_activated, clear_error, fifo_ready;
   logic [3:0]   xadc_alarms;
   logic         acq_trigger, fifo_valid, error_trig_rate;
   logic [4:0]   acq_trig_type, state;
   logic [23:0]  acq_trig_num, trig_num;
   logic [127:0] fifo_data;
   logic [43:0]  trig_timestamp;
   logic [15:0]  dropped_trig_cnt;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [127:0] exp_word;

   localparam logic [4:0] S_IDLE = 5'b00001, S_SEND = 5'b00010, S_WAIT = 5'b00100,
                          S_STORE = 5'b01000, S_ERROR = 5'b10000;

   always #12 clk = ~clk;

   ttc_trigger_receiver_multi dut (
      .clk(clk), .reset_n(reset_n), .reset_trig_num(reset_trig_num),
      .reset_trig_timestamp(reset_trig_timestamp), .ttc_trigger(ttc_trigger),
      .trig_type(trig_type), .chan_en(chan_en), .selftrig_seen(selftrig_seen),
      .acq_ready(acq_ready), .acq_activated(acq_activated), .clear_error(clear_error),
      .xadc_alarms(xadc_alarms), .acq_trigger(acq_trigger), .acq_trig_type(acq_trig_type),
      .acq_trig_num(acq_trig_num), .fifo_ready(fifo_ready), .fifo_valid(fifo_valid),
      .fifo_data(fifo_data), .state(state), .trig_num(trig_num),
      .trig_timestamp(trig_timestamp), .dropped_trig_cnt(dropped_trig_cnt),
      .error_trig_rate(error_trig_rate)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ttc_trigger = 1'b1;
      step(2);
      n_tests++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %b want %b", state, S_IDLE); end
      n_tests++; if (trig_num !== 24'd1) begin n_fail++; $display("FAIL reset_trig_num: got %0d want 1", trig_num); end
      n_tests++; if (acq_trig_num !== 24'd1) begin n_fail++; $display("FAIL reset_acq_trig_num: got %0d want 1", acq_trig_num); end
      n_tests++; if (trig_timestamp !== 44'd0) begin n_fail++; $display("FAIL reset_timestamp: got %0d want 0", trig_timestamp); end
      n_tests++; if (dropped_trig_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", dropped_trig_cnt); end
      n_tests++; if ({acq_trigger, fifo_valid, error_trig_rate} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {acq_trigger, fifo_valid, error_trig_rate}); end
      n_tests++; if (fifo_data !== 128'd0) begin n_fail++; $display("FAIL reset_fifo_data: got %h want 0", fifo_data); end
      n_tests++; if (acq_trig_type !== 5'd0) begin n_fail++; $display("FAIL reset_trig_type: got %0d want 0", acq_trig_type); end
      ttc_trigger = 1'b0; reset_n = 1'b1;
      step(2);
   endtask

   task automatic test_basic_event;
      trig_type = 5'd4; acq_activated = 1'b1; selftrig_seen = 5'b00010; chan_en = 5'b11111;
      xadc_alarms = 4'hA; acq_ready = 1'b1; fifo_ready = 1'b0;
      ttc_trigger = 1'b1; step(1); ttc_trigger = 1'b0;
      n_tests++; if (state !== S_SEND) begin n_fail++; $display("FAIL basic_send: got %b want %b", state, S_SEND); end
      n_tests++; if (acq_trig_num !== 24'd1) begin n_fail++; $display("FAIL basic_acq_num: got %0d want 1", acq_trig_num); end
      n_tests++; if (trig_num !== 24'd2) begin n_fail++; $display("FAIL basic_trig_num: got %0d want 2", trig_num); end
      n_tests++; if (trig_timestamp !== 44'd2) begin n_fail++; $display("FAIL basic_ts: got %0d want 2", trig_timestamp); end
      step(1);
      exp_word = {25'd0, 1'b0, 4'hA, 1'b0, 5'd4, 24'd1, 24'd1, 44'd2};
      n_tests++; if (state !== S_STORE) begin n_fail++; $display("FAIL basic_store: got %b want %b", state, S_STORE); end
      n_tests++; if ({acq_trigger, fifo_valid} !== 2'b11) begin n_fail++; $display("FAIL basic_pulse: got %b want 11", {acq_trigger, fifo_valid}); end
      n_tests++; if (fifo_data !== exp_word) begin n_fail++; $display("FAIL basic_word: got %h want %h", fifo_data, exp_word); end
      fifo_ready = 1'b1; step(1); fifo_ready = 1'b0;
      n_tests++; if ({state, acq_trigger, fifo_valid} !== {S_IDLE, 2'b00}) begin n_fail++; $display("FAIL basic_done: got %b want %b", {state, acq_trigger, fifo_valid}, {S_IDLE, 2'b00}); end
   endtask

   task automatic test_empty_event;
      trig_type = 5'd1;
      ttc_trigger = 1'b1; step(1); ttc_trigger = 1'b0;
      n_tests++; if ({acq_trig_num, trig_num} !== {24'd2, 24'd3}) begin n_fail++; $display("FAIL empty_event_nums: got %0d/%0d want 2/3", acq_trig_num, trig_num); end
      step(1);
      n_tests++; if (acq_trigger !== 1'b0) begin n_fail++; $display("FAIL empty_event_no_acq: got %b want 0", acq_trigger); end
      n_tests++; if (fifo_data[97] !== 1'b1) begin n_fail++; $display("FAIL empty_event_flag: got %b want 1", fifo_data[97]); end
      n_tests++; if (fifo_data[91:68] !== 24'd2) begin n_fail++; $display("FAIL empty_event_cnt: got %0d want 2", fifo_data[91:68]); end
      n_tests++; if ({fifo_data[102], fifo_data[96:92]} !== 6'b000001) begin n_fail++; $display("FAIL empty_event_type: got %b want 000001", {fifo_data[102], fifo_data[96:92]}); end
      fifo_ready = 1'b1; step(1); fifo_ready = 1'b0;
   endtask

   task automatic test_empty_payload;
      trig_type = 5'd4; selftrig_seen = 5'b00100; chan_en = 5'b00011;
      ttc_trigger = 1'b1; step(1); ttc_trigger = 1'b0;
      step(1);
      n_tests++; if (acq_trigger !== 1'b1) begin n_fail++; $display("FAIL payload_acq: got %b want 1", acq_trigger); end
      n_tests++; if ({fifo_data[102], fifo_data[97]} !== 2'b10) begin n_fail++; $display("FAIL payload_flags: got %b want 10", {fifo_data[102], fifo_data[97]}); end
      n_tests++; if ({fifo_data[91:68], fifo_data[67:44]} !== {24'd2, 24'd3}) begin n_fail++; $display("FAIL payload_nums: got %0d/%0d want 2/3", fifo_data[91:68], fifo_data[67:44]); end
      fifo_ready = 1'b1; step(1); fifo_ready = 1'b0;
   endtask

   task automatic test_timeout;
      selftrig_seen = 5'b00010; chan_en = 5'b11111; acq_ready = 1'b0;
      ttc_trigger = 1'b1; step(1); ttc_trigger = 1'b0;
      n_tests++; if (state !== S_SEND) begin n_fail++; $display("FAIL timeout_send: got %b want %b", state, S_SEND); end
`ifdef ACQ_READY_TIMEOUT_EN
      step(1023);
      n_tests++; if (state !== S_WAIT) begin n_fail++; $display("FAIL timeout_wait: got %b want %b", state, S_WAIT); end
`endif
      step(1);
      n_tests++; if ({state, error_trig_rate} !== {S_ERROR, 1'b1}) begin n_fail++; $display("FAIL timeout_error: got %b want %b", {state, error_trig_rate}, {S_ERROR, 1'b1}); end
      step(3);
      n_tests++; if (state !== S_ERROR) begin n_fail++; $display("FAIL error_hold: got %b want %b", state, S_ERROR); end
      clear_error = 1'b1; acq_ready = 1'b1; step(1); clear_error = 1'b0;
      n_tests++; if ({state, error_trig_rate} !== {S_IDLE, 1'b0}) begin n_fail++; $display("FAIL clear_error: got %b want %b", {state, error_trig_rate}, {S_IDLE, 1'b0}); end
      n_tests++; if (trig_num !== 24'd5) begin n_fail++; $display("FAIL error_keeps_count: got %0d want 5", trig_num); end
   endtask

   task automatic test_back_to_back;
      int writes = 0;
      xadc_alarms = 4'h5; reset_trig_timestamp = 1'b1;
      ttc_trigger = 1'b1; step(1); ttc_trigger = 1'b0; reset_trig_timestamp = 1'b0;
      n_tests++; if (trig_timestamp !== 44'd0) begin n_fail++; $display("FAIL ts_reset_latch: got %0d want 0", trig_timestamp); end
      step(1);
      exp_word = {25'd0, 1'b0, 4'h5, 1'b0, 5'd4, 24'd3, 24'd5, 44'd0};
      n_tests++; if (acq_trigger !== 1'b1) begin n_fail++; $display("FAIL stall_acq: got %b want 1", acq_trigger); end
      for (int i = 0; i < 10; i++) begin
         n_tests++; if ({fifo_valid, fifo_data} !== {1'b1, exp_word}) begin n_fail++; $display("FAIL stall_word_%0d: got %b/%h want 1/%h", i, fifo_valid, fifo_data, exp_word); end
         if (i > 0) begin
            n_tests++; if (acq_trigger !== 1'b0) begin n_fail++; $display("FAIL stall_single_pulse_%0d: got %b want 0", i, acq_trigger); end
         end
         if (fifo_valid && fifo_ready) writes++;
         ttc_trigger = (i == 1 || i == 4 || i == 7);
         step(1);
      end
      ttc_trigger = 1'b0;
      n_tests++; if (dropped_trig_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_dropped: got %0d want 3", dropped_trig_cnt); end
      fifo_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (fifo_valid && fifo_ready) writes++;
         step(1);
      end
      fifo_ready = 1'b0;
      n_tests++; if (writes !== 1) begin n_fail++; $display("FAIL stall_writes: got %0d want 1", writes); end
   endtask

   task automatic test_trig_num_wrap;
      force dut.r_trig_num = 24'hFFFFFF;
      #1;
      release dut.r_trig_num;
      fifo_ready = 1'b1;
      ttc_trigger = 1'b1; step(1); ttc_trigger = 1'b0;
      n_tests++; if (acq_trig_num !== 24'd16777215) begin n_fail++; $display("FAIL wrap_latched: got %0d want 16777215", acq_trig_num); end
      n_tests++; if (trig_num !== 24'd0) begin n_fail++; $display("FAIL wrap_trig_num: got %0d want 0", trig_num); end
      step(2);
      n_tests++; if (state !== S_IDLE) begin n_fail++; $display("FAIL wrap_idle: got %b want %b", state, S_IDLE); end
      reset_trig_num = 1'b1; ttc_trigger = 1'b1; step(1); reset_trig_num = 1'b0; ttc_trigger = 1'b0;
      n_tests++; if ({acq_trig_num, trig_num} !== {24'd1, 24'd2}) begin n_fail++; $display("FAIL num_reset_coincident: got %0d/%0d want 1/2", acq_trig_num, trig_num); end
      step(1);
      n_tests++; if ({fifo_data[91:68], fifo_data[67:44]} !== {24'd1, 24'd1}) begin n_fail++; $display("FAIL num_reset_word: got %0d/%0d want 1/1", fifo_data[91:68], fifo_data[67:44]); end
      step(1);
      fifo_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; reset_trig_num = 1'b0; reset_trig_timestamp = 1'b0; ttc_trigger = 1'b0;
      trig_type = 5'd0; chan_en = 5'd0; selftrig_seen = 5'd0; acq_ready = 1'b0;
      acq_activated = 1'b0; clear_error = 1'b0; fifo_ready = 1'b0; xadc_alarms = 4'h0;
      step(1);
      test_reset();
      test_basic_event();
      test_empty_event();
      test_empty_payload();
      test_timeout();
      test_back_to_back();
      test_trig_num_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule

// File: doc/ttc_trigger_receiver_multi.md
TTC_TRIGGER_RECEIVER_MULTI -- requirements
Module: ttc_trigger_receiver_multi

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 5: number of digitizer channels.
REQ-002 SHALL have parameter TRIG_NUM_W, default 24: trigger/event counter width.
REQ-003 SHALL have parameter TS_W, default 44: timestamp width.
REQ-004 SHALL have parameter ASYNC_TYPE, default 5'b00100: the only trig_type that starts an acquisition.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: acq_ready wait limit, in clk cycles.
REQ-006 SHALL have ports:
- clk  in  1  40 MHz TTC clock; one clock.
- reset_n  in  1  synchronous, active-low reset.
- reset_trig_num, reset_trig_timestamp  in  1 each  TTC channel-B counter resets.
- ttc_trigger  in  1  trigger pulse.
- trig_type  in  5  trigger type.
- chan_en  in  NUM_CHAN  enabled channels.
- selftrig_seen  in  NUM_CHAN  per-channel self-trigger flags.
- acq_ready, acq_activated  in  1 each  acquisition controller status.
- clear_error  in  1  leave ERROR.
- xadc_alarms  in  4  XADC alarms.
- acq_trigger  out  1  one-cycle acquisition pulse.
- acq_trig_type  out  5  latched trigger type.
- acq_trig_num  out  TRIG_NUM_W  latched trigger number.
- fifo_ready  in  1  FIFO ready; fifo_valid out 1; fifo_data out 128.
- state  out  5  one-hot state.
- trig_num  out  TRIG_NUM_W  global trigger count.
- trig_timestamp  out  TS_W  latched timestamp.
- dropped_trig_cnt  out  16  triggers ignored outside IDLE.
- error_trig_rate  out  1  high while in ERROR.

Function
REQ-007 SHALL use one-hot states IDLE, SEND, WAIT_RDY, STORE, ERROR.
REQ-008 IDLE + ttc_trigger SHALL latch all of the following, then go to SEND:
- trig_num into acq_trig_num, and increment trig_num;
- trig_type into acq_trig_type;
- free-running timestamp into trig_timestamp;
- xadc_alarms.
REQ-009 On the same IDLE trigger, empty_event SHALL be set if trig_type!=ASYNC_TYPE or ~acq_activated.
REQ-010 Otherwise, empty_payload SHALL be set if (selftrig_seen & chan_en)==0.
REQ-011 SEND with acq_ready SHALL go to STORE; acq_trigger SHALL pulse next cycle, and the event counter SHALL increment, only when empty_event is clear.
REQ-012 SEND without acq_ready SHALL go to WAIT_RDY.
REQ-013 WAIT_RDY SHALL behave as SEND once acq_ready rises; after TIMEOUT_CYC cycles without acq_ready it SHALL go to ERROR.
REQ-014 fifo_valid SHALL be 1 exactly while in STORE.
REQ-015 fifo_data SHALL be {zero pad, empty_payload, alarms[3:0], empty_event, type[4:0], event_cnt, acq_trig_num, trig_timestamp}, LSB-aligned.
REQ-016 STORE SHALL hold until fifo_ready, then clear both flags and return to IDLE; fifo_data SHALL be stable while valid.
REQ-017 ERROR SHALL hold until clear_error, then go to IDLE; counters SHALL be kept.
REQ-018 ttc_trigger outside IDLE SHALL increment dropped_trig_cnt, saturating at 16'hFFFF.
REQ-019 trig_num, the event counter and the timestamp SHALL wrap modulo 2^width.
REQ-020 reset_trig_num SHALL set trig_num, acq_trig_num and the event counter to 1.
REQ-021 reset_trig_num coinciding with an IDLE trigger SHALL latch number 1 and leave trig_num=2.
REQ-022 reset_trig_timestamp SHALL zero the timestamp counter and trig_timestamp; when coinciding with a trigger, it SHALL latch 0.

Reset
REQ-023 reset_n low at a clk edge SHALL force IDLE, mid-operation included, and set:
- trig_num, acq_trig_num and event counter = 1;
- timestamps = 0, dropped_trig_cnt = 0;
- acq_trigger, fifo_valid, fifo_data, flags and acq_trig_type = 0.
REQ-024 A trigger coinciding with reset_n low SHALL be discarded.

Configuration
REQ-025 With ACQ_READY_TIMEOUT_EN defined, SHALL behave as REQ-012/REQ-013.
REQ-026 Without ACQ_READY_TIMEOUT_EN, WAIT_RDY and the timeout counter SHALL be absent, and SEND without acq_ready SHALL go directly to ERROR.

Structure
REQ-027 Package ttc_trig_pkg SHALL hold the state index constants, the FIFO field offsets/widths and the ASYNC_TYPE default.
REQ-028 The timeout counter SHALL be sub-module acq_ready_timeout (start, ready, expired); all else inline.

Verification
REQ-029 Bench SHALL cover these directed scenarios:
- After reset, trigger type 4, acq_activated=1, selftrig_seen=5'b00010, chan_en=5'b11111 -> acq_trigger pulse, fifo word trig_num=1, event_cnt=1, flags 0.
- Trigger type 1 -> no acq_trigger, empty_event=1, event_cnt unchanged, trig_num=2.
- Type 4 with selftrig_seen=5'b00100 and chan_en=5'b00011 -> empty_payload=1, acq_trigger pulses.
- acq_ready low 1024 cycles (macro on) -> ERROR, error_trig_rate=1; clear_error -> IDLE; macro off -> ERROR one cycle after SEND.
- fifo_ready held low 10 cycles plus 3 extra triggers -> data stable, dropped_trig_cnt=3, single FIFO write.
- trig_num at 2^24-1, trigger -> latched 16777215, trig_num wraps to 0; reset_trig_num coincident with trigger -> latched 1, trig_num=2.
